// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder/subtractor. One 1-bit full-adder slice is time-shared
// across WIDTH-bit operands, LSB first, one bit per clock. The carry is held
// in a flip-flop between bits. In subtract mode b is inverted and the carry-in
// is forced to 1 (two's complement).
//
// Ports:
//   clk       system clock, rising-edge active
//   rst_n     asynchronous active-low reset
//   start     request pulse, sampled only in IDLE
//   sub       0 = a+b+cin, 1 = a-b; sampled with start
//   a, b      WIDTH-bit operands; sampled with start
//   cin       carry-in for add mode, ignored when sub=1
//   busy      high while the bit loop runs
//   done      one-cycle pulse, result valid
//   sum       result, held until the next accepted start
//   cout      carry out of MSB (in subtract mode 1 = no borrow)
//   overflow  signed overflow: carry into MSB XOR carry out of MSB
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    // The shared full-adder slice.
    logic s_bit;
    logic c_next;

    always_comb begin
        s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
        c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // NOTE: every register is cleared by the async reset, including the operand
    // shift registers, so an aborted operation leaves no residue behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every term on the
            // right-hand side is the value from before this edge.
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    // Result bits enter at the MSB, so after WIDTH shifts the
                    // first (LSB) result bit has reached position 0.
                    sum   <= (sum >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here.
                        cout     <= c_next;
                        overflow <= carry ^ c_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Bench for serial_add_ctrl at WIDTH=8 (main instance) and WIDTH=1.
// Expected results come from whole-word arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // WIDTH=8 instance
    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ov8;
    logic [7:0] sum8;

    // WIDTH=1 instance
    logic       start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1, ov1;
    logic [0:0] sum1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
        .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1),
        .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ov1)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ov;
    } res_t;

    // Reference: whole-word addition of a, the (possibly inverted) b and the
    // carry-in; overflow by the signed rule (equal operand signs, result sign
    // differs).
    function automatic res_t model(input int w, input logic [31:0] a,
                                   input logic [31:0] b, input logic sub,
                                   input logic cin);
        longint unsigned mask, aa, bb, t;
        res_t r;
        mask   = (64'd1 << w) - 1;
        aa     = {32'd0, a} & mask;
        bb     = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
        t      = aa + bb + (sub ? 64'd1 : {63'd0, cin});
        r.sum  = 32'(t & mask);
        r.cout = t[w];
        r.ov   = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
        return r;
    endfunction

    // Drives one operation on dut8 from #1 after an edge. Returns results at
    // the done pulse, latency in edges from the start edge, number of busy
    // cycles, and done as seen one edge after the pulse. Operands are
    // scrambled right after the start edge; the result must not care.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic cin,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int lat, output int busy_cyc,
                        output logic done_after);
        start8 = 1'b1; a8 = a; b8 = b; sub8 = sub; cin8 = cin;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
        lat = 0;
        busy_cyc = busy8 ? 1 : 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy8 && !done8) busy_cyc++;
        end
        s = sum8; co = cout8; ov = ov8;
        @(posedge clk); #1;
        done_after = done8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({busy8, done8, sum8, cout8, ov8} !== 12'd0)
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ov=%b, expected all 0",
                     busy8, done8, sum8, cout8, ov8);
        else n_pass++;
        n_checks++;
        if ({busy1, done1, sum1, cout1, ov1} !== 5'd0)
            $display("FAIL reset1: got busy=%b done=%b sum=%b cout=%b ov=%b, expected all 0",
                     busy1, done1, sum1, cout1, ov1);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_width1();
        res_t e;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            e = model(1, {31'd0, v[2]}, {31'd0, v[1]}, 1'b0, v[0]);
            start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = 1'b0;
            @(posedge clk); #1;
            start1 = 1'b0;
            n_checks++;
            if (busy1 !== 1'b1) $display("FAIL w1_busy[%0d]: got %b expected 1", i, busy1);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if ({done1, sum1, cout1, ov1} !== {1'b1, e.sum[0], e.cout, e.ov})
                $display("FAIL w1_result[%0d]: got done=%b sum=%b cout=%b ov=%b expected done=1 sum=%b cout=%b ov=%b",
                         i, done1, sum1, cout1, ov1, e.sum[0], e.cout, e.ov);
            else n_pass++;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_directed();
        logic [7:0] s; logic co, ov, da; int lat, bc;
        logic [7:0] ta [4] = '{8'hFF, 8'h7F, 8'h05, 8'h80};
        logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
        logic       ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] xs [4] = '{8'h00, 8'h80, 8'hFE, 8'h7F};
        logic       xc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       xo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run8(ta[i], tb[i], ts[i], 1'b0, s, co, ov, lat, bc, da);
            n_checks++;
            if ({s, co, ov} !== {xs[i], xc[i], xo[i]})
                $display("FAIL dir_result[%0d]: got sum=%h cout=%b ov=%b expected sum=%h cout=%b ov=%b",
                         i, s, co, ov, xs[i], xc[i], xo[i]);
            else n_pass++;
            n_checks++;
            if (lat != 8 || bc != 8 || da !== 1'b0)
                $display("FAIL dir_timing[%0d]: got latency=%0d busy=%0d done_after=%b expected 8 8 0",
                         i, lat, bc, da);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, s; logic sb, ci, co, ov, da; int lat, bc;
        res_t e;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            sb = 1'($urandom); ci = 1'($urandom);
            e = model(8, {24'd0, a}, {24'd0, b}, sb, ci);
            run8(a, b, sb, ci, s, co, ov, lat, bc, da);
            n_checks++;
            if ({s, co, ov} !== {e.sum[7:0], e.cout, e.ov} || lat != 8)
                $display("FAIL rand[%0d] a=%h b=%h sub=%b cin=%b: got sum=%h cout=%b ov=%b lat=%0d expected sum=%h cout=%b ov=%b lat=8",
                         i, a, b, sb, ci, s, co, ov, lat, e.sum[7:0], e.cout, e.ov);
            else n_pass++;
        end
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        logic [7:0] s = '0; logic co = 1'b1;
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                dones++;
                s = sum8; co = cout8;
            end
        end
        n_checks++;
        if (dones != 1 || s !== 8'h46 || co !== 1'b0)
            $display("FAIL ignored_start: got dones=%0d sum=%h cout=%b expected dones=1 sum=46 cout=0",
                     dones, s, co);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        logic [7:0] s; logic co, ov, da; int lat, bc;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; sub8 = 1'b0; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, sum8, cout8, ov8} !== 12'd0)
            $display("FAIL abort_zero: got busy=%b done=%b sum=%h cout=%b ov=%b expected all 0",
                     busy8, done8, sum8, cout8, ov8);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        n_checks++;
        if (dones != 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        else n_pass++;
        run8(8'h0F, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bc, da);
        n_checks++;
        if (s !== 8'h10 || co !== 1'b0 || lat != 8)
            $display("FAIL abort_recover: got sum=%h cout=%b lat=%0d expected sum=10 cout=0 lat=8",
                     s, co, lat);
        else n_pass++;
    endtask

    // Start held from the done cycle: the DONE->IDLE edge must ignore it and
    // the following edge must accept it; result stays put while idle.
    task automatic test_back_to_back();
        logic [7:0] s; logic co, ov, da; int lat, bc;
        res_t e;
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h5A; sub8 = 1'b0; cin8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b1; a8 = 8'hC8; b8 = 8'h64; sub8 = 1'b1; cin8 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy8 !== 1'b0 || sum8 !== 8'h97)
            $display("FAIL b2b_done_edge: got busy=%b sum=%h expected busy=0 sum=97", busy8, sum8);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (busy8 !== 1'b1) $display("FAIL b2b_accept: got busy=%b expected 1", busy8);
        else n_pass++;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = model(8, 32'hC8, 32'h64, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (lat != 8 || sum8 !== e.sum[7:0] || cout8 !== e.cout || ov8 !== e.ov)
            $display("FAIL b2b_hold: got lat=%0d sum=%h cout=%b ov=%b expected lat=8 sum=%h cout=%b ov=%b",
                     lat, sum8, cout8, ov8, e.sum[7:0], e.cout, e.ov);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_width1();
        test_directed();
        test_random();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
